pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub_pkg.sv | 17 +
 rtl/addsub_segment.sv | 17 +
 rtl/pipelined_addsub.sv | 113 +++++++++++
 tb/tb_pipelined_addsub.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared constants, stage-count helper and flag record for pipelined_addsub
package pipelined_addsub_pkg;

  localparam int W_DEF   = 16;
  localparam int SEG_DEF = 4;

  function automatic int num_stages(input int w, input int seg);
    return w / seg;
  endfunction

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

endpackage

// File: rtl/addsub_segment.sv
// rtl/addsub_segment.sv - combinational SEG-bit ripple segment with MSB carry-in tap
module addsub_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           msb_cin_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
  // Carry into the top bit, recovered from its sum bit; xor with cout gives signed overflow.
  assign msb_cin_o = a_i[SEG-1] ^ b_i[SEG-1] ^ sum_o[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-segmented pipelined adder/subtractor with valid/ready backpressure
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int SEG = SEG_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int S = num_stages(W, SEG);

  if (SEG < 1 || SEG > W || (W % SEG) != 0) begin : g_param_check
    $error("pipelined_addsub: W (%0d) must be a nonzero multiple of SEG (%0d)", W, SEG);
  end

  // Operands shift right one segment per stage so the live segment is always at bit 0;
  // resolved sum bits enter at the top and shift down into place.
  typedef struct packed {
    logic         valid;
    logic [W-1:0] a_rem;
    logic [W-1:0] b_rem;
    logic [W-1:0] sum_done;
    logic         carry;
  } stage_t;

  stage_t         st_q [S];
  stage_t         st_d [S];
  logic [SEG-1:0] seg_sum [S];
  logic [S-1:0]   seg_cout;
  logic [S-1:0]   seg_msb_cin;
  logic           adv;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   sum_q, sum_d, sum_fin;
  flags_t         flags_q, flags_d;

  for (genvar i = 0; i < S; i++) begin : g_seg
    addsub_segment #(.SEG(SEG)) u_seg (
      .a_i       (st_q[i].a_rem[SEG-1:0]),
      .b_i       (st_q[i].b_rem[SEG-1:0]),
      .cin_i     (st_q[i].carry),
      .sum_o     (seg_sum[i]),
      .cout_o    (seg_cout[i]),
      .msb_cin_o (seg_msb_cin[i])
    );
  end

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign sum_fin  = (st_q[S-1].sum_done >> SEG) | (W'(seg_sum[S-1]) << (W - SEG));

  always_comb begin
    for (int i = 0; i < S; i++) st_d[i] = st_q[i];
    st_d[0].valid = in_valid;
    if (in_valid) begin
      st_d[0].a_rem    = a;
      st_d[0].b_rem    = b ^ {W{sub}};
      st_d[0].sum_done = '0;
      st_d[0].carry    = cin;
    end
    for (int i = 1; i < S; i++) begin
      st_d[i].valid    = st_q[i-1].valid;
      st_d[i].a_rem    = st_q[i-1].a_rem >> SEG;
      st_d[i].b_rem    = st_q[i-1].b_rem >> SEG;
      st_d[i].sum_done = (st_q[i-1].sum_done >> SEG) | (W'(seg_sum[i-1]) << (W - SEG));
      st_d[i].carry    = seg_cout[i-1];
    end
    out_valid_d = st_q[S-1].valid;
    sum_d       = sum_q;
    flags_d     = flags_q;
    // Bubbles leave the last result on the outputs untouched.
    if (st_q[S-1].valid) begin
      sum_d        = sum_fin;
      flags_d.cout = seg_cout[S-1];
      flags_d.ovf  = seg_cout[S-1] ^ seg_msb_cin[S-1];
      flags_d.zero = ~|sum_fin;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < S; i++) st_q[i] <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      for (int i = 0; i < S; i++) st_q[i] <= st_d[i];
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub at three W/SEG settings
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, cin, sub, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [15:0] sum;
  logic        in_ready16, out_valid16, cout16, ovf16, zero16;
  logic [15:0] sum16;
  logic        in_ready8, out_valid8, cout8, ovf8, zero8;
  logic [7:0]  sum8;

  int          tests = 0;
  int          fails = 0;
  logic [18:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [18:0] held = '0;
  int          rcv = 0;
  int          n_extra = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.W(16), .SEG(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_addsub #(.W(16), .SEG(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(1'b1),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16));

  pipelined_addsub #(.W(8), .SEG(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid8), .out_ready(1'b1),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));

  // Reference: plain integer arithmetic; returns {ovf, zero, cout, sum}.
  function automatic logic [18:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv, input logic sv);
    int unsigned m, x, y, r, s_m;
    int          sx, sy, t;
    logic        ov;
    m   = (32'd1 << w) - 32'd1;
    x   = 32'(av) & m;
    y   = 32'(sv ? ~bv : bv) & m;
    r   = x + y + 32'(cv);
    s_m = r & m;
    sx  = (x > (m >> 1)) ? int'(x) - int'(m) - 1 : int'(x);
    sy  = (y > (m >> 1)) ? int'(y) - int'(m) - 1 : int'(y);
    t   = sx + sy + int'(cv);
    ov  = (t > int'(m >> 1)) || (t < -int'((m >> 1) + 1));
    return {ov, s_m == 0, r[w], 16'(s_m)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One beat into all three instances; latency counted in edges, acceptance edge = 1.
  task automatic directed(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv);
    logic [18:0] got4, got16, got8;
    int          lat4, lat16, lat8;
    lat4 = 0; lat16 = 0; lat8 = 0;
    got4 = '0; got16 = '0; got8 = '0;
    out_ready = 1'b1;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      if (out_valid && lat4 == 0) begin lat4 = n; got4 = {ovf, zero, cout, sum}; end
      if (out_valid16 && lat16 == 0) begin lat16 = n; got16 = {ovf16, zero16, cout16, sum16}; end
      if (out_valid8 && lat8 == 0) begin lat8 = n; got8 = {ovf8, zero8, cout8, 8'h00, sum8}; end
    end
    chk({tag, "_lat_s4"}, lat4, 5);
    chk({tag, "_res_s4"}, got4, model(16, av, bv, cv, sv));
    chk({tag, "_lat_s16"}, lat16, 2);
    chk({tag, "_res_s16"}, got16, model(16, av, bv, cv, sv));
    chk({tag, "_lat_w8"}, lat8, 9);
    chk({tag, "_res_w8"}, got8, model(8, av, bv, cv, sv));
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev) chk("stall_hold", {ovf, zero, cout, sum}, held);
      stall_prev = out_valid && !out_ready;
      held       = {ovf, zero, cout, sum};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) n_extra++;
        else begin
          chk("stream_res", {ovf, zero, cout, sum}, exp_q.pop_front());
          rcv++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, guard;
    logic need_new, stale;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {ovf, zero, cout, sum}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    directed("add_basic", 16'h1234, 16'h0FED, 1'b0, 1'b0);
    directed("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);

    mon_en = 1'b1; sent = 0; guard = 0; need_new = 1'b1;
    while (sent < 20 && guard < 400) begin
      if (need_new) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        need_new = 1'b0;
      end
      in_valid = 1'b1; out_ready = 1'($urandom);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(16, a, b, cin, sub));
        sent++; need_new = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 800) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("stream_sent", sent, 20);
    chk("stream_count", rcv, 20);
    chk("extra_results", n_extra, 0);

    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h3333; b = 16'h0444;
    @(posedge clk); #1;
    a = 16'h5555; b = 16'h0666;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", {ovf, zero, cout, sum}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    stale = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      stale = stale | out_valid;
    end
    chk("no_stale", stale, 0);
    directed("post_rst", 16'hABCD, 16'h1234, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
